pipeline_controller: RTL and testbench
======================================

Name: pipeline_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Collects stall requests from ID, EX and MEM, plus exceptions, and produces the single stall vector consumed by the PC register and every inter-stage buffer.
- Runs an internal down-counter so multi-cycle EX operations (div, madd/msub) hold the pipe without the EX stage asserting a request every cycle.
- Issues a one-cycle flush with the handler PC on an exception.

Parameters:
- COUNT_WIDTH, 6, width of the multi-cycle length field and the remaining-cycle counter.
- EXCEPTION_VECTOR, 32'h00000020, handler address when exception_type = 0 (general).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- id_stall_request  in  1  load-use hazard from ID.
- ex_stall_request  in  1  generic EX hold request.
- mem_stall_request  in  1  data-memory wait.
- ex_multicycle_start  in  1  pulse: EX began a multi-cycle op.
- ex_multicycle_cycles  in  COUNT_WIDTH  total EX cycles N of that op.
- exception_valid  in  1  MEM stage raises an exception this cycle.
- exception_type  in  1  0 = general (EXCEPTION_VECTOR), 1 = eret (use exception_epc).
- exception_epc  in  `INST_ADDR_BUS  return address for eret.
- stall  out  `SIGNAL_BUS (6)  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- flush  out  1  clear all inter-stage buffers.
- new_program_counter  out  `INST_ADDR_BUS  PC target while flush = 1.
- ex_multicycle_done  out  1  final cycle of a multi-cycle op.
- busy  out  1  state != RUN.

Behaviour:
- Stall patterns use the codebase stall convention: stall[i] enabled with stall[i+1] disabled makes buffer i+1 take a bubble.
  - ID: 6'b000111
  - EX: 6'b001111
  - MEM: 6'b011111
  - none: 6'b000000
- Priority: flush > MEM > EX (request or internal counter) > ID.
- stall is combinational from state, counter and requests. flush, new_program_counter and ex_multicycle_done are registered.
- FSM states: RUN, MULTI, FLUSH.
- RUN:
  - exception_valid -> FLUSH. Latch new_program_counter: EXCEPTION_VECTOR if type 0, else exception_epc.
  - else ex_multicycle_start with N >= 2 -> MULTI, remaining <= N-1. The start cycle itself drives the EX pattern (unless MEM overrides).
  - start with N = 0 or 1: no stall, done pulses next cycle, stay in RUN.
- MULTI:
  - Drive the EX pattern while remaining > 1.
  - Each cycle without mem_stall_request: remaining decrements. While mem_stall_request is asserted, remaining freezes and the MEM pattern is driven.
  - When remaining == 1 and no MEM stall: stall is not forced by the counter, ex_multicycle_done = 1 next cycle, state -> RUN.
  - ex_multicycle_start is ignored in MULTI.
  - exception_valid aborts: remaining <= 0, -> FLUSH, no done pulse.
  - Net effect: an op of N cycles stalls EX for exactly N-1 cycles absent MEM stalls.
- FLUSH:
  - flush = 1 for exactly one cycle, stall = 0.
  - Always returns to RUN. Inputs during FLUSH are ignored, including a second exception_valid.
- Simultaneous exception_valid and ex_multicycle_start: the exception wins and the counter is not loaded.
- ID and EX requests during FLUSH are masked.
- Reset (async, any state): state = RUN, remaining = 0, flush = 0, new_program_counter = 0, ex_multicycle_done = 0. Outputs stall = 0 and busy = 0 while reset is high.

Optional Feature:
- STALL_STATS_EN
- Defined:
  - Adds output stall_cycle_count [31:0] and flush_count [15:0].
  - stall_cycle_count increments on every cycle with stall[0] = 1.
  - flush_count increments on every cycle with flush = 1.
  - Both saturate at all-ones and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared macro header: stall pattern constants (STALL_NONE/ID/EX/MEM), FSM state encodings, exception type codes, EXCEPTION_VECTOR default.
- Natural sub-module: multicycle_counter (load/decrement/freeze/abort with last-cycle flag), instantiated once.

Test Plan:
- Reset mid-MULTI (N = 10, after 3 cycles): asserting reset -> stall = 0, busy = 0, flush = 0 immediately, no done pulse afterwards.
- id_stall_request = 1 alone for 2 cycles -> stall = 6'b000111 both cycles; id + mem together -> 6'b011111.
- ex_multicycle_start, N = 5, no other requests -> stall = 6'b001111 for 4 cycles (including start), then 0; ex_multicycle_done high on cycle 5 only.
- N = 5 with mem_stall_request high for 2 cycles during MULTI -> 6'b011111 for those cycles, counter frozen; total stalled cycles = 6; done still single-cycle.
- exception_valid with type 0 during MULTI -> next cycle flush = 1, new_program_counter = 32'h00000020, stall = 0; then RUN with no done pulse. Type 1 with epc = 32'h00400104 -> new_program_counter = 32'h00400104.
- Same-cycle exception_valid and ex_multicycle_start (N = 8) -> FLUSH taken, busy low after one cycle, no EX stall pattern.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: stall vector
// patterns, FSM state encodings, exception type codes and the default
// exception handler address.
package pipeline_controller_pkg;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int SIGNAL_WIDTH    = 6;

  // stall[i] set with stall[i+1] clear makes buffer i+1 take a bubble.
  localparam logic [SIGNAL_WIDTH-1:0] STALL_NONE = 6'b000000;
  localparam logic [SIGNAL_WIDTH-1:0] STALL_ID   = 6'b000111;
  localparam logic [SIGNAL_WIDTH-1:0] STALL_EX   = 6'b001111;
  localparam logic [SIGNAL_WIDTH-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MULTI = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_t;

  localparam logic EXC_GENERAL = 1'b0;
  localparam logic EXC_ERET    = 1'b1;

  localparam logic [INST_ADDR_WIDTH-1:0] EXCEPTION_VECTOR_DEFAULT = 32'h0000_0020;

  // Resolve competing hold requests: the deeper stage wins because its
  // pattern already freezes every earlier stage.
  function automatic logic [SIGNAL_WIDTH-1:0] select_stall(input logic mem_hold,
                                                           input logic ex_hold,
                                                           input logic id_hold);
    logic [SIGNAL_WIDTH-1:0] pattern;
    pattern = STALL_NONE;
    if (mem_hold)     pattern = STALL_MEM;
    else if (ex_hold) pattern = STALL_EX;
    else if (id_hold) pattern = STALL_ID;
    return pattern;
  endfunction

endpackage

// File: rtl/pipeline_controller_multicycle_counter.sv
// Remaining-cycle counter for multi-cycle EX operations. Loads N-1 on start,
// counts down while advanced, freezes otherwise and clears on abort. Flags
// the last cycle (remaining == 1) and whether the counter still forces EX.
module pipeline_controller_multicycle_counter #(
  parameter int COUNT_WIDTH = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic                   advance,
  input  logic                   abort,
  output logic [COUNT_WIDTH-1:0] remaining,
  output logic                   last,
  output logic                   active
);

  logic [COUNT_WIDTH-1:0] remaining_reg;
  logic [COUNT_WIDTH-1:0] remaining_next;

  // Abort beats load beats decrement; a zero counter never wraps.
  always_comb begin
    remaining_next = remaining_reg;
    if (abort) begin
      remaining_next = '0;
    end else if (load) begin
      remaining_next = load_value;
    end else if (advance && (remaining_reg != '0)) begin
      remaining_next = remaining_reg - COUNT_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      remaining_reg <= '0;
    end else begin
      remaining_reg <= remaining_next;
    end
  end

  assign remaining = remaining_reg;
  assign last      = (remaining_reg == COUNT_WIDTH'(1));
  assign active    = (remaining_reg > COUNT_WIDTH'(1));

endmodule

// File: rtl/pipeline_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline. Merges ID/EX/MEM
// hold requests, sequences multi-cycle EX operations with an internal
// counter and issues a one-cycle flush carrying the handler PC on exceptions.
// Optional build macro STALL_STATS_EN adds saturating stall/flush counters.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int                         COUNT_WIDTH      = 6,
  parameter logic [INST_ADDR_WIDTH-1:0] EXCEPTION_VECTOR = EXCEPTION_VECTOR_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       id_stall_request,
  input  logic                       ex_stall_request,
  input  logic                       mem_stall_request,
  input  logic                       ex_multicycle_start,
  input  logic [COUNT_WIDTH-1:0]     ex_multicycle_cycles,
  input  logic                       exception_valid,
  input  logic                       exception_type,
  input  logic [INST_ADDR_WIDTH-1:0] exception_epc,
  output logic [SIGNAL_WIDTH-1:0]    stall,
  output logic                       flush,
  output logic [INST_ADDR_WIDTH-1:0] new_program_counter,
  output logic                       ex_multicycle_done,
  output logic                       busy
`ifdef STALL_STATS_EN
  ,
  output logic [31:0]                stall_cycle_count,
  output logic [15:0]                flush_count
`endif
);

  ctrl_state_t state_reg;
  ctrl_state_t state_next;

  logic                       flush_reg;
  logic                       flush_next;
  logic                       done_reg;
  logic                       done_next;
  logic [INST_ADDR_WIDTH-1:0] new_pc_reg;
  logic [INST_ADDR_WIDTH-1:0] new_pc_next;
  logic [INST_ADDR_WIDTH-1:0] handler_pc;

  logic                       counter_load;
  logic                       counter_advance;
  logic                       counter_abort;
  logic [COUNT_WIDTH-1:0]     counter_remaining;
  logic                       counter_last;
  logic                       counter_active;
  logic                       counter_hold_ex;
  logic                       multi_start_long;

  // An op of N cycles holds EX for N-1 cycles, so only N >= 2 enters MULTI.
  assign multi_start_long = ex_multicycle_start && (ex_multicycle_cycles > COUNT_WIDTH'(1));

  pipeline_controller_multicycle_counter #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_multicycle_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (counter_load),
    .load_value (ex_multicycle_cycles - COUNT_WIDTH'(1)),
    .advance    (counter_advance),
    .abort      (counter_abort),
    .remaining  (counter_remaining),
    .last       (counter_last),
    .active     (counter_active)
  );

  // Pick the flush target from the exception type.
  always_comb begin
    handler_pc = EXCEPTION_VECTOR;
    case (exception_type)
      EXC_GENERAL: handler_pc = EXCEPTION_VECTOR;
      EXC_ERET:    handler_pc = exception_epc;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic, counter control, registered-output next values and
  // the combinational stall vector.
  always_comb begin
    state_next      = state_reg;
    counter_load    = 1'b0;
    counter_advance = 1'b0;
    counter_abort   = 1'b0;
    counter_hold_ex = 1'b0;
    flush_next      = 1'b0;
    done_next       = 1'b0;
    new_pc_next     = new_pc_reg;
    stall           = STALL_NONE;

    unique case (state_reg)
      ST_RUN: begin
        if (exception_valid) begin
          // Exception wins over a same-cycle start; the counter stays idle.
          state_next  = ST_FLUSH;
          flush_next  = 1'b1;
          new_pc_next = handler_pc;
        end else if (multi_start_long) begin
          state_next      = ST_MULTI;
          counter_load    = 1'b1;
          counter_hold_ex = 1'b1;
        end else if (ex_multicycle_start) begin
          // Zero/one-cycle ops finish immediately without stalling.
          done_next = 1'b1;
        end
      end
      ST_MULTI: begin
        counter_hold_ex = counter_active;
        if (exception_valid) begin
          state_next    = ST_FLUSH;
          counter_abort = 1'b1;
          flush_next    = 1'b1;
          new_pc_next   = handler_pc;
        end else if (!mem_stall_request) begin
          // A MEM wait freezes the count; otherwise one EX cycle elapses.
          counter_advance = 1'b1;
          if (counter_last) begin
            state_next = ST_RUN;
            done_next  = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase

    // Flush cycles and reset force an empty stall vector.
    if (!reset && (state_reg != ST_FLUSH)) begin
      stall = select_stall(mem_stall_request,
                           ex_stall_request || counter_hold_ex,
                           id_stall_request);
    end
  end

  // Registered flush, handler PC and done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flush_reg  <= 1'b0;
      done_reg   <= 1'b0;
      new_pc_reg <= '0;
    end else begin
      flush_reg  <= flush_next;
      done_reg   <= done_next;
      new_pc_reg <= new_pc_next;
    end
  end

  assign flush               = flush_reg;
  assign ex_multicycle_done  = done_reg;
  assign new_program_counter = new_pc_reg;
  assign busy                = !reset && (state_reg != ST_RUN);

`ifdef STALL_STATS_EN
  logic [31:0] stall_cycle_count_reg;
  logic [15:0] flush_count_reg;

  // Saturating counts of PC-stall cycles and flush cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycle_count_reg <= '0;
      flush_count_reg       <= '0;
    end else begin
      if (stall[0] && (stall_cycle_count_reg != '1)) begin
        stall_cycle_count_reg <= stall_cycle_count_reg + 32'd1;
      end
      if (flush_reg && (flush_count_reg != '1)) begin
        flush_count_reg <= flush_count_reg + 16'd1;
      end
    end
  end

  assign stall_cycle_count = stall_cycle_count_reg;
  assign flush_count       = flush_count_reg;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_pipeline_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_stall_request;
  logic        ex_stall_request;
  logic        mem_stall_request;
  logic        ex_multicycle_start;
  logic [5:0]  ex_multicycle_cycles;
  logic        exception_valid;
  logic        exception_type;
  logic [31:0] exception_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_program_counter;
  logic        ex_multicycle_done;
  logic        busy;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cycle_count;
  logic [15:0] flush_count;
`endif

  int checks_total  = 0;
  int checks_passed = 0;

  pipeline_controller dut (
    .clock                (clock),
    .reset                (reset),
    .id_stall_request     (id_stall_request),
    .ex_stall_request     (ex_stall_request),
    .mem_stall_request    (mem_stall_request),
    .ex_multicycle_start  (ex_multicycle_start),
    .ex_multicycle_cycles (ex_multicycle_cycles),
    .exception_valid      (exception_valid),
    .exception_type       (exception_type),
    .exception_epc        (exception_epc),
    .stall                (stall),
    .flush                (flush),
    .new_program_counter  (new_program_counter),
    .ex_multicycle_done   (ex_multicycle_done),
    .busy                 (busy)
`ifdef STALL_STATS_EN
    ,
    .stall_cycle_count    (stall_cycle_count),
    .flush_count          (flush_count)
`endif
  );

  always #5 clock = ~clock;

  // ---------------- behavioural reference model ----------------
  // owed_cycles: EX cycles of the current op still to run after this one.
  int          owed_cycles;
  logic        flush_now;
  logic        done_now;
  logic [31:0] target_pc;
  int          model_stall_cycles;
  int          model_flushes;
  logic [5:0]  exp_stall;
  logic        exp_flush;
  logic        exp_busy;
  logic        exp_done;
  logic [31:0] exp_pc;

  task automatic model_reset();
    owed_cycles = 0;
    flush_now   = 1'b0;
    done_now    = 1'b0;
    target_pc   = 32'h0;
    model_stall_cycles = 0;
    model_flushes      = 0;
  endtask

  // Expected outputs for the current cycle given the applied inputs.
  task automatic model_eval();
    logic counter_forces_ex;
    exp_flush = flush_now;
    exp_done  = done_now;
    exp_pc    = target_pc;
    exp_busy  = flush_now || (owed_cycles > 0);
    counter_forces_ex = (owed_cycles >= 2) ||
                        (owed_cycles == 0 && ex_multicycle_start &&
                         ex_multicycle_cycles >= 2 && !exception_valid);
    if (flush_now)                                     exp_stall = 6'b000000;
    else if (mem_stall_request)                        exp_stall = 6'b011111;
    else if (ex_stall_request || counter_forces_ex)    exp_stall = 6'b001111;
    else if (id_stall_request)                         exp_stall = 6'b000111;
    else                                               exp_stall = 6'b000000;
  endtask

  // Apply the rules of the current cycle at the clock edge.
  task automatic model_advance();
    logic finishing;
    finishing = 1'b0;
    if (exp_stall[0]) model_stall_cycles++;
    if (exp_flush)    model_flushes++;
    if (flush_now) begin
      flush_now = 1'b0;
    end else if (exception_valid) begin
      flush_now   = 1'b1;
      target_pc   = exception_type ? exception_epc : 32'h0000_0020;
      owed_cycles = 0;
    end else if (owed_cycles > 0) begin
      if (!mem_stall_request) begin
        owed_cycles--;
        finishing = (owed_cycles == 0);
      end
    end else if (ex_multicycle_start) begin
      if (ex_multicycle_cycles >= 2) owed_cycles = int'(ex_multicycle_cycles) - 1;
      else                           finishing = 1'b1;
    end
    done_now = finishing;
  endtask

  task automatic drive_idle();
    id_stall_request     = 1'b0;
    ex_stall_request     = 1'b0;
    mem_stall_request    = 1'b0;
    ex_multicycle_start  = 1'b0;
    ex_multicycle_cycles = 6'd0;
    exception_valid      = 1'b0;
    exception_type       = 1'b0;
    exception_epc        = 32'h0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    id_stall_request  = 1'b1;
    mem_stall_request = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks_total++;
    if ({stall, flush, busy, ex_multicycle_done, new_program_counter} !== {6'b0, 1'b0, 1'b0, 1'b0, 32'h0})
      $display("FAIL reset_state: got stall=%b flush=%b busy=%b done=%b pc=%h, want all zero",
               stall, flush, busy, ex_multicycle_done, new_program_counter);
    else checks_passed++;
    drive_idle();
    reset = 1'b0;
    model_reset();
    $display("test_reset: outputs under reset checked");
  endtask

  task automatic test_id_mem();
    for (int c = 0; c < 4; c++) begin
      drive_idle();
      id_stall_request  = 1'b1;
      mem_stall_request = (c == 2);
      model_eval();
      @(negedge clock);
      checks_total++;
      if ({stall, flush, busy, ex_multicycle_done, new_program_counter} !== {exp_stall, exp_flush, exp_busy, exp_done, exp_pc})
        $display("FAIL id_mem c%0d: got %b/%b/%b/%b/%h want %b/%b/%b/%b/%h", c,
                 stall, flush, busy, ex_multicycle_done, new_program_counter,
                 exp_stall, exp_flush, exp_busy, exp_done, exp_pc);
      else checks_passed++;
      checks_total++;
      if (stall !== ((c == 2) ? 6'b011111 : 6'b000111))
        $display("FAIL id_mem_pattern c%0d: got %b want %b", c, stall, (c == 2) ? 6'b011111 : 6'b000111);
      else checks_passed++;
      @(posedge clock); model_advance(); #1;
    end
    drive_idle();
    $display("test_id_mem: 4 cycles of ID / ID+MEM requests");
  endtask

  task automatic test_multicycle(input int mem_first, input int mem_len,
                                 input int want_stalled, input int want_done_at);
    int stalled = 0, done_count = 0, done_at = -1;
    for (int c = 0; c < 11; c++) begin
      drive_idle();
      if (c == 0) begin ex_multicycle_start = 1'b1; ex_multicycle_cycles = 6'd5; end
      mem_stall_request = (c >= mem_first) && (c < mem_first + mem_len);
      model_eval();
      @(negedge clock);
      checks_total++;
      if ({stall, flush, busy, ex_multicycle_done, new_program_counter} !== {exp_stall, exp_flush, exp_busy, exp_done, exp_pc})
        $display("FAIL multicycle c%0d: got %b/%b/%b/%b/%h want %b/%b/%b/%b/%h", c,
                 stall, flush, busy, ex_multicycle_done, new_program_counter,
                 exp_stall, exp_flush, exp_busy, exp_done, exp_pc);
      else checks_passed++;
      if (stall != 6'b0) stalled++;
      if (ex_multicycle_done) begin done_count++; done_at = c; end
      @(posedge clock); model_advance(); #1;
    end
    checks_total++;
    if (stalled != want_stalled || done_count != 1 || done_at != want_done_at)
      $display("FAIL multicycle_totals: got stalled=%0d done=%0d at %0d want stalled=%0d done=1 at %0d",
               stalled, done_count, done_at, want_stalled, want_done_at);
    else checks_passed++;
    drive_idle();
    $display("test_multicycle: N=5, mem stall %0d cycles, stalled %0d", mem_len, stalled);
  endtask

  task automatic test_exception(input logic during_multi, input logic typ,
                                input logic [31:0] epc, input logic [31:0] want_pc);
    int done_count = 0;
    logic saw_flush = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive_idle();
      if (during_multi && c == 0) begin ex_multicycle_start = 1'b1; ex_multicycle_cycles = 6'd8; end
      if (c == (during_multi ? 3 : 0)) begin
        exception_valid = 1'b1; exception_type = typ; exception_epc = epc;
      end
      // a second exception during the flush cycle must be ignored
      if (c == (during_multi ? 4 : 1)) begin
        exception_valid = 1'b1; exception_type = 1'b1; exception_epc = 32'hDEAD_BEE0;
        mem_stall_request = 1'b1;
      end
      model_eval();
      @(negedge clock);
      checks_total++;
      if ({stall, flush, busy, ex_multicycle_done, new_program_counter} !== {exp_stall, exp_flush, exp_busy, exp_done, exp_pc})
        $display("FAIL exception c%0d: got %b/%b/%b/%b/%h want %b/%b/%b/%b/%h", c,
                 stall, flush, busy, ex_multicycle_done, new_program_counter,
                 exp_stall, exp_flush, exp_busy, exp_done, exp_pc);
      else checks_passed++;
      if (ex_multicycle_done) done_count++;
      if (flush && !saw_flush) begin
        saw_flush = 1'b1;
        checks_total++;
        if (new_program_counter !== want_pc || stall !== 6'b0)
          $display("FAIL exception_target: got pc=%h stall=%b want pc=%h stall=000000",
                   new_program_counter, stall, want_pc);
        else checks_passed++;
      end
      @(posedge clock); model_advance(); #1;
    end
    checks_total++;
    if (!saw_flush || done_count != 0)
      $display("FAIL exception_summary: got flush_seen=%b done_pulses=%0d want 1 and 0", saw_flush, done_count);
    else checks_passed++;
    drive_idle();
    $display("test_exception: type=%0d target=%h", typ, want_pc);
  endtask

  task automatic test_same_cycle();
    int ex_pattern = 0;
    for (int c = 0; c < 4; c++) begin
      drive_idle();
      if (c == 0) begin
        exception_valid = 1'b1; ex_multicycle_start = 1'b1; ex_multicycle_cycles = 6'd8;
      end
      model_eval();
      @(negedge clock);
      checks_total++;
      if ({stall, flush, busy, ex_multicycle_done, new_program_counter} !== {exp_stall, exp_flush, exp_busy, exp_done, exp_pc})
        $display("FAIL same_cycle c%0d: got %b/%b/%b/%b/%h want %b/%b/%b/%b/%h", c,
                 stall, flush, busy, ex_multicycle_done, new_program_counter,
                 exp_stall, exp_flush, exp_busy, exp_done, exp_pc);
      else checks_passed++;
      if (stall == 6'b001111) ex_pattern++;
      if (c == 2) begin
        checks_total++;
        if (busy !== 1'b0) $display("FAIL same_cycle_busy: got %b want 0", busy);
        else checks_passed++;
      end
      @(posedge clock); model_advance(); #1;
    end
    checks_total++;
    if (ex_pattern != 0) $display("FAIL same_cycle_ex: got %0d EX cycles want 0", ex_pattern);
    else checks_passed++;
    drive_idle();
    $display("test_same_cycle: exception beats multicycle start");
  endtask

  task automatic test_reset_mid_multi();
    int done_count = 0;
    for (int c = 0; c < 4; c++) begin
      drive_idle();
      if (c == 0) begin ex_multicycle_start = 1'b1; ex_multicycle_cycles = 6'd10; end
      @(posedge clock); model_advance(); #1;
    end
    id_stall_request  = 1'b1;
    mem_stall_request = 1'b1;
    reset = 1'b1;
    #1;
    checks_total++;
    if ({stall, busy, flush} !== 8'b0)
      $display("FAIL reset_mid_multi: got stall=%b busy=%b flush=%b want 0/0/0", stall, busy, flush);
    else checks_passed++;
    repeat (2) @(posedge clock);
    #1;
    drive_idle();
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 14; c++) begin
      model_eval();
      @(negedge clock);
      checks_total++;
      if ({stall, flush, busy, ex_multicycle_done, new_program_counter} !== {exp_stall, exp_flush, exp_busy, exp_done, exp_pc})
        $display("FAIL after_reset c%0d: got %b/%b/%b/%b/%h want %b/%b/%b/%b/%h", c,
                 stall, flush, busy, ex_multicycle_done, new_program_counter,
                 exp_stall, exp_flush, exp_busy, exp_done, exp_pc);
      else checks_passed++;
      if (ex_multicycle_done) done_count++;
      @(posedge clock); model_advance(); #1;
    end
    checks_total++;
    if (done_count != 0) $display("FAIL reset_no_done: got %0d done pulses want 0", done_count);
    else checks_passed++;
    $display("test_reset_mid_multi: reset during N=10 op");
  endtask

  task automatic test_random(input int cycles);
    int errors = 0;
    for (int c = 0; c < cycles; c++) begin
      drive_idle();
      id_stall_request     = ($urandom_range(0, 3) == 0);
      ex_stall_request     = ($urandom_range(0, 7) == 0);
      mem_stall_request    = ($urandom_range(0, 4) == 0);
      ex_multicycle_start  = ($urandom_range(0, 5) == 0);
      ex_multicycle_cycles = 6'($urandom_range(0, 12));
      exception_valid      = ($urandom_range(0, 24) == 0);
      exception_type       = 1'($urandom_range(0, 1));
      exception_epc        = $urandom;
      model_eval();
      @(negedge clock);
      checks_total++;
      if ({stall, flush, busy, ex_multicycle_done, new_program_counter} !== {exp_stall, exp_flush, exp_busy, exp_done, exp_pc}) begin
        errors++;
        $display("FAIL random c%0d: got %b/%b/%b/%b/%h want %b/%b/%b/%b/%h", c,
                 stall, flush, busy, ex_multicycle_done, new_program_counter,
                 exp_stall, exp_flush, exp_busy, exp_done, exp_pc);
      end else checks_passed++;
      @(posedge clock); model_advance(); #1;
    end
    drive_idle();
    $display("test_random: %0d cycles, %0d differences", cycles, errors);
  endtask

`ifdef STALL_STATS_EN
  task automatic test_stats();
    checks_total++;
    if (stall_cycle_count !== 32'(model_stall_cycles) || flush_count !== 16'(model_flushes))
      $display("FAIL stats: got stall_cycles=%0d flushes=%0d want %0d %0d",
               stall_cycle_count, flush_count, model_stall_cycles, model_flushes);
    else checks_passed++;
  endtask
`endif

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_id_mem();
    test_multicycle(99, 0, 4, 5);
    test_multicycle(2, 2, 6, 7);
    test_exception(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0020);
    test_exception(1'b0, 1'b1, 32'h0040_0104, 32'h0040_0104);
    test_same_cycle();
    test_random(400);
`ifdef STALL_STATS_EN
    test_stats();
`endif
    test_reset_mid_multi();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
